demux_scan_sequencer: RTL and testbench
=======================================

# demux_scan_sequencer

Upstream channel sequencer for the demux write controller. It holds a small configuration register file (start channel, stop channel, dwell time, control bits) and produces a stream of 5-bit channel requests over a valid/ready handshake. The downstream controller turns each accepted request into the demux address, CS and WR strobes. The block supports continuous or single-shot scans, with a programmable dwell between channel switches.

## Interface
Parameters:
- `CH_W`, 5: channel address width; 32 demux channels.
- `DWELL_W`, 8: dwell counter width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_we`  in  1  register write strobe, one cycle per write.
- `cfg_addr`  in  2  register select: 0 START, 1 STOP, 2 DWELL, 3 CTRL.
- `cfg_wdata`  in  8  write data. START and STOP use bits [CH_W-1:0]. CTRL uses bit0 `run` and bit1 `single`.
- `req_valid`  out  1  channel request valid (registered).
- `req_ch`  out  CH_W  requested channel (registered). Stable while `req_valid` is high.
- `req_ready`  in  1  downstream accepts the request.
- `busy`  out  1  high in any state other than IDLE.
- `scan_done`  out  1  one-cycle pulse when the STOP channel's dwell completes.

## Operation
- Reset values:
  - START=0, STOP=31, DWELL=0, CTRL=0.
  - `req_valid`=0, `req_ch`=0, `busy`=0, `scan_done`=0.
  - State is IDLE.
- FSM states: IDLE, ISSUE, DWELL.
- IDLE:
  - Stays in IDLE while `run`=0.
  - When `run`=1: `cur`←START, then go to ISSUE.
- ISSUE:
  - `req_valid`=1 and `req_ch`=`cur`.
  - Holds until `req_valid & req_ready`. Valid is never withdrawn before the handshake completes.
  - On handshake: load the dwell counter with the DWELL register value, then go to DWELL.
- DWELL:
  - Lasts DWELL+1 cycles. DWELL=0 therefore gives a one-cycle gap with `req_valid` low, so back-to-back requests never occur.
  - At dwell end with `cur`≠STOP: `cur`←`cur`+1 modulo 32 (31 wraps to 0), then go to ISSUE.
  - At dwell end with `cur`==STOP: pulse `scan_done`. If `single`=1, clear `run` and go to IDLE. Otherwise `cur`←START and go to ISSUE.
- START>STOP is legal. The scan wraps through 31→0, e.g. START=30, STOP=1 gives 30, 31, 0, 1.
- Config update points:
  - START is sampled only when `cur` is loaded.
  - STOP is compared live, at each dwell end.
  - DWELL is sampled on entry to DWELL.
- `run` cleared by a write in ISSUE:
  - The pending request still completes its handshake.
  - The FSM then goes to IDLE; the DWELL state is skipped and no `scan_done` pulse is produced.
- `run` cleared by a write in DWELL: go to IDLE next cycle, with no `scan_done` pulse.
- A CTRL write and a handshake in the same cycle: the handshake counts, and the FSM acts on the new `run` value.
- `rst` mid-operation: outputs and registers return to reset values on that edge. Any in-flight request is dropped.

## Timing
- A CTRL write with `run`=1 on edge k: state is ISSUE and `req_valid`=1 from edge k+1.
- Handshake on edge h: `req_valid`=0 from h. The next `req_valid` rises at edge h+DWELL+1.
- Per-channel period with `req_ready` tied high: DWELL+2 cycles.
- `scan_done` is high for exactly the one cycle in which the FSM leaves the final DWELL.
- No combinational path from `req_ready` to `req_valid` or `req_ch`.

## Structure
- Shared package `demux_pkg` holds:
  - `CH_W` and `DWELL_W` defaults.
  - Register address constants `REG_START`, `REG_STOP`, `REG_DWELL`, `REG_CTRL`.
  - CTRL bit indices.
  - State enum `scan_state_t` (IDLE, ISSUE, DWELL).
- One sub-module, `dwell_timer`:
  - Inputs: load, value, enable.
  - Output: `expired`.
  - Down-counter of width `DWELL_W`.
- Register file and FSM live in the top module.

## Test plan
- Reset, then write START=3, STOP=5, DWELL=2, CTRL=0b11 with `req_ready`=1 → requests 3, 4, 5 at 4-cycle spacing; `scan_done` pulses once; `busy` falls; CTRL reads `run`=0.
- START=30, STOP=1, DWELL=0, continuous mode → sequence 30, 31, 0, 1, 30, … with a 2-cycle period; `scan_done` pulses after each channel 1.
- `req_ready` held low for 10 cycles in ISSUE → `req_valid` and `req_ch` stay constant; the sequence resumes unchanged once `req_ready` rises.
- CTRL `run`=0 written in the same cycle as a handshake on channel 7 → channel 7 is accepted, IDLE on the next cycle, no further requests, no `scan_done`.
- `rst` asserted during DWELL with DWELL=200 → next cycle: all outputs 0, `busy`=0, STOP reads 31.
- STOP rewritten from 20 to 4 while the scan is at channel 2 → the scan ends after channel 4 with one `scan_done` pulse.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the demux scan sequencer.
// Register map, CTRL bit positions and the scan FSM state type.
package demux_pkg;

    localparam int CH_W_DFLT    = 5;
    localparam int DWELL_W_DFLT = 8;

    localparam logic [1:0] REG_START = 2'd0;
    localparam logic [1:0] REG_STOP  = 2'd1;
    localparam logic [1:0] REG_DWELL = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_SINGLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DWELL = 2'd2
    } scan_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that flags expiry once it reaches zero.
// Holds at zero until reloaded.
module dwell_timer
    import demux_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    input  logic               enable,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/demux_scan_sequencer.sv
// Channel scan sequencer: config registers plus an IDLE/ISSUE/DWELL FSM
// issuing channel requests over a registered valid/ready handshake.
module demux_scan_sequencer
    import demux_pkg::*;
#(
    parameter int CH_W    = CH_W_DFLT,
    parameter int DWELL_W = DWELL_W_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic            req_valid,
    output logic [CH_W-1:0] req_ch,
    input  logic            req_ready,
    output logic            busy,
    output logic            scan_done
);

    logic [CH_W-1:0]    start_q, start_d;
    logic [CH_W-1:0]    stop_q, stop_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               run_q, run_d, run_wr;
    logic               single_q, single_d;
    scan_state_t        state_q, state_d;
    logic [CH_W-1:0]    cur_q, cur_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               tmr_load;
    logic               tmr_exp;
    logic               hs;

    assign hs = valid_q & req_ready;

    always_comb begin
        start_d  = start_q;
        stop_d   = stop_q;
        dwell_d  = dwell_q;
        run_wr   = run_q;
        single_d = single_q;
        if (cfg_we) begin
            unique case (cfg_addr)
                REG_START: start_d = cfg_wdata[CH_W-1:0];
                REG_STOP:  stop_d  = cfg_wdata[CH_W-1:0];
                REG_DWELL: dwell_d = cfg_wdata[DWELL_W-1:0];
                REG_CTRL: begin
                    run_wr   = cfg_wdata[CTRL_RUN];
                    single_d = cfg_wdata[CTRL_SINGLE];
                end
                default: ;
            endcase
        end
    end

    // A same-cycle CTRL write is honoured via run_wr in ISSUE/DWELL.
    always_comb begin
        run_d    = run_wr;
        state_d  = state_q;
        cur_d    = cur_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    cur_d   = start_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hs) begin
                    if (!run_wr) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                if (!run_wr) begin
                    state_d = ST_IDLE;
                end else if (tmr_exp) begin
                    if (cur_q == stop_q) begin
                        done_d = 1'b1;
                        if (single_d) begin
                            run_d   = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            cur_d   = start_q;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= '0;
            stop_q   <= '1;
            dwell_q  <= '0;
            run_q    <= 1'b0;
            single_q <= 1'b0;
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            start_q  <= start_d;
            stop_q   <= stop_d;
            dwell_q  <= dwell_d;
            run_q    <= run_d;
            single_q <= single_d;
            state_q  <= state_d;
            cur_q    <= cur_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (dwell_q),
        .enable  (state_q == ST_DWELL),
        .expired (tmr_exp)
    );

    assign req_valid = valid_q;
    assign req_ch    = cur_q;
    assign busy      = (state_q != ST_IDLE);
    assign scan_done = done_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed bench for demux_scan_sequencer; observations are packed as
// {req_valid, busy, scan_done, req_ch} and sampled on the falling edge.
module tb_demux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       req_valid;
    logic [4:0] req_ch;
    logic       req_ready;
    logic       busy;
    logic       scan_done;

    int checks   = 0;
    int failures = 0;
    int tbl[$];

    always #5 clk = ~clk;

    demux_scan_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_ready (req_ready),
        .busy      (busy),
        .scan_done (scan_done)
    );

    function automatic int e(int v, int b, int d, int ch);
        return (v << 7) | (b << 6) | (d << 5) | ch;
    endfunction

    function automatic int obs();
        return int'({req_valid, busy, scan_done, req_ch});
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int o, input int x);
        checks++;
        assert (o === x) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, o, x);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic run_tbl(input string tag, input bit pre);
        foreach (tbl[i]) begin
            if (pre || i > 0) step();
            chk($sformatf("%s_%0d", tag, i), obs(), tbl[i]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 8'd0;
        req_ready = 1'b1;
        step();
        step();
        chk("reset", obs(), e(0, 0, 0, 0));
        rst = 1'b0;
        step();
        chk("post_reset", obs(), e(0, 0, 0, 0));

        // single-shot 3..5 with dwell 2
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd5);
        wr(2'd2, 8'd2);
        wr(2'd3, 8'd3);
        tbl = '{e(0,0,0,0),
                e(1,1,0,3), e(0,1,0,3), e(0,1,0,3), e(0,1,0,3),
                e(1,1,0,4), e(0,1,0,4), e(0,1,0,4), e(0,1,0,4),
                e(1,1,0,5), e(0,1,0,5), e(0,1,0,5), e(0,1,0,5),
                e(0,0,1,5), e(0,0,0,5), e(0,0,0,5), e(0,0,0,5)};
        run_tbl("single", 1'b0);

        // continuous wrap 30..1 with dwell 0
        wr(2'd0, 8'd30);
        wr(2'd1, 8'd1);
        wr(2'd2, 8'd0);
        wr(2'd3, 8'd1);
        tbl = '{e(0,0,0,5),
                e(1,1,0,30), e(0,1,0,30), e(1,1,0,31), e(0,1,0,31),
                e(1,1,0,0), e(0,1,0,0), e(1,1,0,1), e(0,1,0,1),
                e(1,1,1,30), e(0,1,0,30)};
        run_tbl("wrap", 1'b0);

        // stall: ready low for 10 cycles while channel 31 is offered
        req_ready = 1'b0;
        tbl = {};
        for (int i = 0; i < 10; i++) tbl.push_back(e(1, 1, 0, 31));
        run_tbl("stall", 1'b1);
        req_ready = 1'b1;
        tbl = '{e(0,1,0,31), e(1,1,0,0), e(0,1,0,0),
                e(1,1,0,1), e(0,1,0,1), e(1,1,1,30)};
        run_tbl("resume", 1'b1);

        // run cleared in the same cycle as the handshake on channel 7
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2", obs(), e(0, 0, 0, 0));
        wr(2'd0, 8'd7);
        wr(2'd1, 8'd10);
        wr(2'd2, 8'd0);
        req_ready = 1'b0;
        wr(2'd3, 8'd1);
        chk("stop_idle", obs(), e(0, 0, 0, 0));
        step();
        chk("stop_req7", obs(), e(1, 1, 0, 7));
        req_ready = 1'b1;
        wr(2'd3, 8'd0);
        tbl = '{e(0,0,0,7), e(0,0,0,7), e(0,0,0,7), e(0,0,0,7)};
        run_tbl("stop_after", 1'b0);

        // reset during a long dwell
        wr(2'd2, 8'd200);
        wr(2'd0, 8'd2);
        wr(2'd1, 8'd20);
        wr(2'd3, 8'd1);
        tbl = '{e(0,0,0,7), e(1,1,0,2),
                e(0,1,0,2), e(0,1,0,2), e(0,1,0,2), e(0,1,0,2)};
        run_tbl("long_dwell", 1'b0);
        rst = 1'b1;
        step();
        chk("mid_rst", obs(), e(0, 0, 0, 0));
        rst = 1'b0;

        // reset STOP=31, DWELL=0, CTRL=0 observed through behaviour
        wr(2'd0, 8'd29);
        chk("rst_ctrl0", obs(), e(0, 0, 0, 0));
        step();
        chk("rst_ctrl0b", obs(), e(0, 0, 0, 0));
        wr(2'd3, 8'd3);
        tbl = '{e(0,0,0,0),
                e(1,1,0,29), e(0,1,0,29), e(1,1,0,30), e(0,1,0,30),
                e(1,1,0,31), e(0,1,0,31), e(0,0,1,31), e(0,0,0,31)};
        run_tbl("rst_stop", 1'b0);

        // STOP lowered from 20 to 4 while channel 2 is offered
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd20);
        wr(2'd2, 8'd1);
        wr(2'd3, 8'd3);
        tbl = '{e(0,0,0,31),
                e(1,1,0,0), e(0,1,0,0), e(0,1,0,0),
                e(1,1,0,1), e(0,1,0,1), e(0,1,0,1),
                e(1,1,0,2)};
        run_tbl("live_stop_a", 1'b0);
        wr(2'd1, 8'd4);
        tbl = '{e(0,1,0,2), e(0,1,0,2),
                e(1,1,0,3), e(0,1,0,3), e(0,1,0,3),
                e(1,1,0,4), e(0,1,0,4), e(0,1,0,4),
                e(0,0,1,4), e(0,0,0,4), e(0,0,0,4)};
        run_tbl("live_stop_b", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
